// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake body engine.
package snake_pkg;

  localparam int unsigned GRID_W     = 8;
  localparam int unsigned GRID_CELLS = GRID_W * GRID_W;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
  } vec2_t;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    UP    = 2'd3
  } dir_t;

  typedef enum logic {
    RUN  = 1'b0,
    OVER = 1'b1
  } state_t;

  // Move one cell in direction d; 3-bit arithmetic gives the mod-8 wrap.
  function automatic vec2_t step(vec2_t p, dir_t d);
    vec2_t r;
    r = p;
    case (d)
      RIGHT:   r.x = p.x + 3'd1;
      DOWN:    r.y = p.y + 3'd1;
      LEFT:    r.x = p.x - 3'd1;
      default: r.y = p.y - 3'd1;
    endcase
    return r;
  endfunction

  // Opposite headings differ by exactly 2 in the encoding.
  function automatic logic is_reverse(dir_t a, dir_t b);
    return (2'(a) ^ 2'(b)) == 2'd2;
  endfunction

  // Starting body cell k, laid out row-major from (0,0).
  function automatic vec2_t init_cell(int unsigned k);
    vec2_t r;
    r.x = 3'(k % GRID_W);
    r.y = 3'(k / GRID_W);
    return r;
  endfunction

  // Flat grid bit index of a coordinate: 8*y + x.
  function automatic logic [5:0] cell_idx(vec2_t p);
    return {p.y, p.x};
  endfunction

  // Occupancy of the starting body: the lowest n cells in row-major order.
  function automatic logic [GRID_CELLS-1:0] init_grid(int unsigned n);
    logic [GRID_CELLS-1:0] g;
    for (int unsigned k = 0; k < GRID_CELLS; k++) begin
      g[k] = (k < n);
    end
    return g;
  endfunction

endpackage

// File: rtl/snake_pos_fifo.sv
// Circular buffer of body coordinates; head is the newest entry, tail the oldest.
module snake_pos_fifo
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned INIT_LEN = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        init,
  input  logic                        push,
  input  logic                        pop,
  input  vec2_t                       push_data,
  output vec2_t                       head_o,
  output vec2_t                       tail_o,
  output logic [$clog2(MAX_LEN):0]    count
);

  localparam int unsigned PW = $clog2(MAX_LEN);
  localparam int unsigned CW = PW + 1;

  vec2_t          mem_q [MAX_LEN];
  vec2_t          mem_d [MAX_LEN];
  logic [PW-1:0]  hp_q, hp_d;
  logic [PW-1:0]  tp_q, tp_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Next-state: restart reloads the initial body, otherwise push/pop (possibly both).
  always_comb begin
    mem_d = mem_q;
    hp_d  = hp_q;
    tp_d  = tp_q;
    cnt_d = cnt_q;
    if (init) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        mem_d[i] = (i < INIT_LEN) ? init_cell(i) : vec2_t'('0);
      end
      hp_d  = PW'(INIT_LEN - 1);
      tp_d  = '0;
      cnt_d = CW'(INIT_LEN);
    end else begin
      if (push) begin
        hp_d        = hp_q + PW'(1);
        mem_d[hp_d] = push_data;
      end
      if (pop) begin
        tp_d = tp_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Buffer registers; async reset loads the initial body.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        mem_q[i] <= (i < INIT_LEN) ? init_cell(i) : vec2_t'('0);
      end
      hp_q  <= PW'(INIT_LEN - 1);
      tp_q  <= '0;
      cnt_q <= CW'(INIT_LEN);
    end else begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        mem_q[i] <= mem_d[i];
      end
      hp_q  <= hp_d;
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o = mem_q[hp_q];
  assign tail_o = mem_q[tp_q];
  assign count  = cnt_q;

endmodule

// File: rtl/snake_body_engine.sv
// Snake game state: heading, stepping, self-collision and incremental occupancy grid.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned INIT_LEN = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       dir_valid,
  input  logic [1:0]                 dir,
  input  logic                       grow,
  input  logic                       start,
  output logic [63:0]                grid,
  output logic [2:0]                 head_x,
  output logic [2:0]                 head_y,
  output logic [$clog2(MAX_LEN):0]   length,
  output logic                       game_over
);

  localparam int unsigned CW = $clog2(MAX_LEN) + 1;
  localparam logic [GRID_CELLS-1:0] INIT_GRID = init_grid(INIT_LEN);
  localparam vec2_t INIT_HEAD = init_cell(INIT_LEN - 1);

  state_t                 state_q, state_d;
  dir_t                   heading_q, heading_d;
  logic [GRID_CELLS-1:0]  grid_q, grid_d;
  vec2_t                  head_q, head_d;
  logic                   go_q, go_d;

  logic                   push_c, pop_c, init_c;
  vec2_t                  body_head, body_tail;
  logic [CW-1:0]          body_len;

  dir_t                   eff_dir;
  vec2_t                  nxt;
  logic                   tail_pops;
  logic                   hit;

  snake_pos_fifo #(
    .MAX_LEN  (MAX_LEN),
    .INIT_LEN (INIT_LEN)
  ) u_body (
    .clk       (clk),
    .rst_n     (reset),
    .init      (init_c),
    .push      (push_c),
    .pop       (pop_c),
    .push_data (nxt),
    .head_o    (body_head),
    .tail_o    (body_tail),
    .count     (body_len)
  );

  // Next-state and step decision; a step either commits fully or ends the game.
  always_comb begin
    state_d   = state_q;
    heading_d = heading_q;
    grid_d    = grid_q;
    head_d    = head_q;
    go_d      = go_q;
    push_c    = 1'b0;
    pop_c     = 1'b0;
    init_c    = 1'b0;

    eff_dir = heading_q;
    if (dir_valid && !is_reverse(dir_t'(dir), heading_q)) begin
      eff_dir = dir_t'(dir);
    end
    heading_d = eff_dir;

    nxt       = step(body_head, eff_dir);
    tail_pops = !(grow && (body_len < CW'(MAX_LEN)));
    // Moving into the cell the tail vacates this same step is legal.
    hit       = grid_q[cell_idx(nxt)] && !(tail_pops && (nxt == body_tail));

    case (state_q)
      RUN: begin
        if (tick) begin
          if (hit) begin
            state_d = OVER;
            go_d    = 1'b1;
          end else begin
            push_c = 1'b1;
            pop_c  = tail_pops;
            if (tail_pops) begin
              grid_d[cell_idx(body_tail)] = 1'b0;
            end
            grid_d[cell_idx(nxt)] = 1'b1;
            head_d = nxt;
          end
        end
      end
      OVER: begin
        if (start) begin
          state_d   = RUN;
          go_d      = 1'b0;
          init_c    = 1'b1;
          grid_d    = INIT_GRID;
          head_d    = INIT_HEAD;
          heading_d = RIGHT;
        end
      end
    endcase
  end

  // Game-state registers; async reset restores the starting position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      heading_q <= RIGHT;
      grid_q    <= INIT_GRID;
      head_q    <= INIT_HEAD;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      heading_q <= heading_d;
      grid_q    <= grid_d;
      head_q    <= head_d;
      go_q      <= go_d;
    end
  end

  assign grid      = grid_q;
  assign head_x    = head_q.x;
  assign head_y    = head_q.y;
  assign length    = body_len;
  assign game_over = go_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine with a queue-based reference model.
module tb_snake_body_engine;

  localparam int MAXL = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        dir_valid = 1'b0;
  logic [1:0]  dir = 2'd0;
  logic        grow = 1'b0;
  logic        start = 1'b0;
  logic [63:0] grid;
  logic [2:0]  head_x, head_y;
  logic [4:0]  length;
  logic        game_over;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  snake_body_engine #(.MAX_LEN(16), .INIT_LEN(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .dir_valid (dir_valid),
    .dir       (dir),
    .grow      (grow),
    .start     (start),
    .grid      (grid),
    .head_x    (head_x),
    .head_y    (head_y),
    .length    (length),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  // Reference model: body as a list of cell numbers (8*y+x), oldest first.
  int m_body[$];
  int m_dir;
  bit m_over;
  int dx[4] = '{1, 0, -1, 0};
  int dy[4] = '{0, 1, 0, -1};

  task automatic model_reset();
    m_body.delete();
    m_body.push_back(0);
    m_body.push_back(1);
    m_body.push_back(2);
    m_dir  = 0;
    m_over = 1'b0;
  endtask

  function automatic logic [63:0] model_grid();
    logic [63:0] g;
    g = '0;
    foreach (m_body[i]) g[m_body[i]] = 1'b1;
    return g;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_reset();
    end else begin
      int nd, hx, hy, nc, first;
      bit pops, coll;
      nd = m_dir;
      if (dir_valid && (int'(dir) != (m_dir + 2) % 4)) nd = int'(dir);
      m_dir = nd;
      if (m_over) begin
        if (start) model_reset();
      end else if (tick) begin
        hx   = m_body[$] % 8;
        hy   = m_body[$] / 8;
        nc   = ((hy + dy[nd] + 8) % 8) * 8 + ((hx + dx[nd] + 8) % 8);
        pops = !(grow && m_body.size() < MAXL);
        first = pops ? 1 : 0;
        coll = 1'b0;
        for (int i = first; i < m_body.size(); i++) begin
          if (m_body[i] == nc) coll = 1'b1;
        end
        if (coll) begin
          m_over = 1'b1;
        end else begin
          m_body.push_back(nc);
          if (pops) void'(m_body.pop_front());
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("grid", grid, model_grid());
      check("head_x", 64'(head_x), 64'(m_body[$] % 8));
      check("head_y", 64'(head_y), 64'(m_body[$] / 8));
      check("length", 64'(length), 64'(m_body.size()));
      check("game_over", 64'(game_over), 64'(m_over));
    end
  end

  task automatic do_step(input logic v, input logic [1:0] d, input logic g);
    tick = 1'b1; dir_valid = v; dir = d; grow = g;
    @(posedge clk);
    #1;
    tick = 1'b0; dir_valid = 1'b0; grow = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string nm, input logic [63:0] g, input int hx, input int hy,
                              input int len, input logic go);
    check({nm, "_grid"}, grid, g);
    check({nm, "_hx"}, 64'(head_x), 64'(hx));
    check({nm, "_hy"}, 64'(head_y), 64'(hy));
    check({nm, "_len"}, 64'(length), 64'(len));
    check({nm, "_go"}, 64'(game_over), 64'(go));
  endtask

  initial begin
    #12;
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    #1;
    expect_state("reset", 64'h07, 2, 0, 3, 1'b0);

    // Five steps right, then one more wraps the head to column 0.
    repeat (5) do_step(1'b0, 2'd0, 1'b0);
    expect_state("right5", 64'hE0, 7, 0, 3, 1'b0);
    do_step(1'b0, 2'd0, 1'b0);
    expect_state("wrap", 64'hC1, 0, 0, 3, 1'b0);

    // Reversal request is dropped; step continues right.
    do_reset();
    do_step(1'b1, 2'd2, 1'b0);
    expect_state("rev", 64'h0E, 3, 0, 3, 1'b0);

    // Growing three times.
    do_reset();
    repeat (3) do_step(1'b0, 2'd0, 1'b1);
    expect_state("grow3", 64'h3F, 5, 0, 6, 1'b0);
    check("grow3_popcount", 64'($countones(grid)), 64'd6);

    // Turn back into the body: DOWN, LEFT, UP hits (3,0).
    do_reset();
    repeat (2) do_step(1'b0, 2'd0, 1'b1);
    do_step(1'b1, 2'd1, 1'b0);
    do_step(1'b1, 2'd2, 1'b0);
    check("pre_hit_go", 64'(game_over), 64'd0);
    do_step(1'b1, 2'd3, 1'b0);
    expect_state("hit", 64'h181C, 3, 1, 5, 1'b1);
    repeat (2) do_step(1'b0, 2'd0, 1'b0);
    expect_state("over_tick", 64'h181C, 3, 1, 5, 1'b1);

    // Restart with a simultaneous tick: start wins.
    start = 1'b1; tick = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; tick = 1'b0;
    expect_state("restart", 64'h07, 2, 0, 3, 1'b0);
    do_step(1'b0, 2'd0, 1'b0);
    check("restart_run_hx", 64'(head_x), 64'd3);

    // 2x2 loop of length 4: head repeatedly enters the cell the tail vacates.
    do_reset();
    do_step(1'b0, 2'd0, 1'b1);
    do_step(1'b1, 2'd1, 1'b0);
    do_step(1'b1, 2'd2, 1'b0);
    do_step(1'b1, 2'd3, 1'b0);
    expect_state("loop", 64'h0C0C, 2, 0, 4, 1'b0);
    do_step(1'b1, 2'd0, 1'b0);
    do_step(1'b1, 2'd1, 1'b0);
    do_step(1'b1, 2'd2, 1'b0);
    expect_state("loop2", 64'h0C0C, 2, 1, 4, 1'b0);

    // Asynchronous reset between clock edges.
    do_step(1'b1, 2'd3, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    expect_state("async_rst", 64'h07, 2, 0, 3, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
